stopwatch_lap_core: RTL and testbench
=====================================

Name: stopwatch_lap_core

Overview:
Parametrised stopwatch/timer core with a built-in tick prescaler, an N-digit BCD counter, up/down mode and lap (split) hold. It sits between the debounced button pulses and the FND controller. The FND controller takes o_bcd directly, so no binary-to-BCD conversion is needed. Down mode turns the block into a countdown timer that stops itself at zero.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ, must be integer and >= 2
DIGITS, 4, number of BCD digits (1..8)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_run_stop  input  1  single-cycle debounced pulse; toggles run/stop
i_clear  input  1  single-cycle pulse; clears/loads the counter (acts only when stopped)
i_lap  input  1  single-cycle pulse; freezes or releases the displayed value
i_down  input  1  level; 1 = countdown mode; sampled only on STOP->run transitions and on clear
i_preset  input  4*DIGITS  BCD countdown start value, loaded on clear when i_down=1
o_bcd  output  4*DIGITS  displayed value: live count, or lap register while lap is held
o_running  output  1  1 in RUN and LAP_RUN
o_lap_active  output  1  1 in LAP_RUN and LAP_STOP
o_tick  output  1  registered single-cycle prescaler pulse; only pulses while running
o_wrap  output  1  single-cycle pulse on up-mode rollover from all-9s to 0
o_done  output  1  single-cycle pulse when the countdown reaches 0

Behaviour:
- Reset: state=STOP, count=0, lap=0, prescaler=0, mode=up, all outputs 0.
- FSM states: STOP, RUN, LAP_RUN, LAP_STOP.
- Input priority: if several pulses arrive in the same cycle, run_stop > lap > clear; lower-priority pulses are dropped.
- STOP transitions:
  - run_stop -> RUN, latching mode <= i_down.
  - clear -> stay in STOP; count <= 0 (i_down=0) or i_preset (i_down=1); prescaler <= 0.
  - lap -> ignored.
- RUN transitions:
  - run_stop -> STOP.
  - lap -> LAP_RUN, with lap <= count as of the same edge.
  - clear -> ignored.
- LAP_RUN: count keeps running while o_bcd shows lap.
  - lap -> RUN.
  - run_stop -> LAP_STOP.
- LAP_STOP:
  - run_stop -> LAP_RUN.
  - lap -> STOP.
  - clear -> STOP, with count cleared/loaded as in STOP.
- o_bcd = lap in the LAP_* states, otherwise count (combinational mux of registers).
- Prescaler:
  - Counts 0..DIV-1 only while running; holds its value while stopped.
  - o_tick=1 for the one cycle after the prescaler reaches DIV-1. The first tick after a cold start comes DIV cycles after entering RUN.
- Counter update: on o_tick=1, count updates at the next edge (latency 1 cycle from the tick).
- Up mode:
  - Per-digit BCD increment with ripple carry; a digit at 9 with carry-in goes to 0 and carries out.
  - All-9s rolls over to 0, pulses o_wrap, and keeps running.
- Down mode:
  - BCD decrement with borrow.
  - When count becomes 0: o_done pulses in that cycle and the FSM goes to STOP (LAP_RUN goes to LAP_STOP).
  - Entering run with count=0 in down mode: pulse o_done on the first tick and return to STOP; the count stays 0.
- i_preset digits > 9 are clamped to 9 on load.
- i_down changes while running: no effect until the next STOP->run transition.
- Reset mid-run: immediate asynchronous return to the reset values.

Decomposition:
- stopwatch_pkg holds:
  - the state encoding (STOP=2'd0, RUN=2'd1, LAP_RUN=2'd2, LAP_STOP=2'd3);
  - the function computing DIV and the prescaler width ($clog2(DIV));
  - the BCD digit-max constant 4'd9.
- One natural sub-module: bcd_digit, a single 4-bit BCD digit with en, up/down, load, carry/borrow in and out. It is instantiated DIGITS times in a generate chain.

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DIGITS=4):
- Up count: reset, then run_stop pulse; after 10 ticks (100 cycles) -> o_bcd=16'h0010, o_running=1; run_stop -> count holds at 0010 for 500 cycles.
- Rollover: preload count to 9998 via a down-mode clear with i_preset=16'h9998, then switch to up mode and run; after 2 ticks -> o_bcd=0000 with o_wrap pulsing for one cycle; counting continues to 0001.
- Lap: run to 0025; lap pulse -> o_bcd frozen at 0025 with o_lap_active=1 while the live count reaches 0040; second lap pulse -> o_bcd=0040, o_lap_active=0.
- Countdown: i_down=1, i_preset=16'h0003, clear, run; after 3 ticks -> o_bcd=0000, o_done pulses once, state=STOP, o_running=0.
- Simultaneous inputs: in STOP, pulse run_stop and clear in the same cycle -> RUN is entered and count is unchanged; clear pulse during RUN -> ignored.
- Asynchronous reset mid-LAP_RUN: all outputs are 0 within the same cycle; state=STOP; the next run starts from 0000.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/lap core: FSM encoding, prescaler sizing
// helpers and BCD digit constants.
// Contents: state_t, BCD_MAX, calc_div(), calc_psc_w(), clamp_digit().
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP     = 2'd0,
        RUN      = 2'd1,
        LAP_RUN  = 2'd2,
        LAP_STOP = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Number of core clocks per count tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Prescaler register width; DIV >= 2 guarantees a width of at least 1.
    function automatic int calc_psc_w(input int div);
        return $clog2(div);
    endfunction

    // Preset digits above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch counter: synchronous load, or step up/down
// when enabled and carry/borrow-in is set. Ports: clk, reset, en, up, load,
// load_val, cin -> value (registered), nxt (combinational next value), cout.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       cin,
    output logic [3:0] value,
    output logic [3:0] nxt,
    output logic       cout
);

    always_comb begin
        nxt  = value;
        cout = 1'b0;
        if (en && cin) begin
            if (up) begin
                cout = (value == BCD_MAX);
                nxt  = (value == BCD_MAX) ? 4'd0 : value + 4'd1;
            end else begin
                // Borrow out when stepping below zero.
                cout = (value == 4'd0);
                nxt  = (value == 4'd0) ? BCD_MAX : value - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_val;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/countdown core: tick prescaler, DIGITS-wide BCD counter, up/down
// mode and lap hold. Inputs: clk, reset, i_run_stop/i_clear/i_lap pulses,
// i_down level, i_preset. Outputs: o_bcd, o_running, o_lap_active, o_tick, o_wrap, o_done.
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int DIGITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_run_stop,
    input  logic                i_clear,
    input  logic                i_lap,
    input  logic                i_down,
    input  logic [4*DIGITS-1:0] i_preset,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_running,
    output logic                o_lap_active,
    output logic                o_tick,
    output logic                o_wrap,
    output logic                o_done
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PSC_W = calc_psc_w(DIV);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

    state_t              state, state_nxt;
    logic                mode_down;
    logic [PSC_W-1:0]    psc;
    logic [4*DIGITS-1:0] count, count_nxt, lap_q, load_val;
    logic [DIGITS:0]     carry;
    logic                rs, lp, cl;
    logic                do_clear, do_lap_cap, mode_set;
    logic                count_zero, count_en, done_evt, wrap_evt;
    logic                running, running_nxt;

    // One pulse per cycle wins: run_stop over lap over clear.
    assign rs = i_run_stop;
    assign lp = i_lap & ~i_run_stop;
    assign cl = i_clear & ~i_run_stop & ~i_lap;

    assign running     = (state == RUN) || (state == LAP_RUN);
    assign running_nxt = (state_nxt == RUN) || (state_nxt == LAP_RUN);

    // A down-count sitting at zero must not borrow round to all-9s.
    assign count_zero = (count == '0);
    assign count_en   = o_tick && !(mode_down && count_zero);
    assign done_evt   = o_tick && mode_down && (count_nxt == '0);
    assign wrap_evt   = o_tick && !mode_down && carry[DIGITS];

    always_comb begin
        state_nxt  = state;
        do_clear   = 1'b0;
        do_lap_cap = 1'b0;
        mode_set   = 1'b0;
        if (done_evt) begin
            // Countdown expiry stops the clock but keeps any lap hold.
            state_nxt = (state == LAP_RUN) ? LAP_STOP : STOP;
        end else begin
            case (state)
                STOP: begin
                    if (rs) begin
                        state_nxt = RUN;
                        mode_set  = 1'b1;
                    end else if (cl) begin
                        do_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (rs) begin
                        state_nxt = STOP;
                    end else if (lp) begin
                        state_nxt  = LAP_RUN;
                        do_lap_cap = 1'b1;
                    end
                end
                LAP_RUN: begin
                    if (rs)      state_nxt = LAP_STOP;
                    else if (lp) state_nxt = RUN;
                end
                LAP_STOP: begin
                    if (rs) begin
                        state_nxt = LAP_RUN;
                    end else if (lp) begin
                        state_nxt = STOP;
                    end else if (cl) begin
                        state_nxt = STOP;
                        do_clear  = 1'b1;
                    end
                end
                default: state_nxt = STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STOP;
            mode_down <= 1'b0;
            psc       <= '0;
            lap_q     <= '0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mode_set || do_clear) mode_down <= i_down;
            if (do_clear) begin
                psc <= '0;
            end else if (running) begin
                psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
            end
            if (do_lap_cap) lap_q <= count;
            // Suppress a tick that would land after the clock has stopped.
            o_tick <= running && (psc == PSC_LAST) && running_nxt;
            o_wrap <= wrap_evt;
            o_done <= done_evt;
        end
    end

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign load_val[4*i +: 4] = i_down ? clamp_digit(i_preset[4*i +: 4]) : 4'd0;

        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .en       (count_en),
            .up       (!mode_down),
            .load     (do_clear),
            .load_val (load_val[4*i +: 4]),
            .cin      (carry[i]),
            .value    (count[4*i +: 4]),
            .nxt      (count_nxt[4*i +: 4]),
            .cout     (carry[i+1])
        );
    end

    assign o_bcd        = o_lap_active ? lap_q : count;
    assign o_running    = running;
    assign o_lap_active = (state == LAP_RUN) || (state == LAP_STOP);

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core with DIV=10, DIGITS=4. Expected values
// go into a scoreboard queue at each step and are popped against DUT outputs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_lap_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_run_stop, i_clear, i_lap, i_down;
    logic [15:0] i_preset;
    logic [15:0] o_bcd;
    logic        o_running, o_lap_active, o_tick, o_wrap, o_done;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    stopwatch_lap_core #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .DIGITS  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run_stop   (i_run_stop),
        .i_clear      (i_clear),
        .i_lap        (i_lap),
        .i_down       (i_down),
        .i_preset     (i_preset),
        .o_bcd        (o_bcd),
        .o_running    (o_running),
        .o_lap_active (o_lap_active),
        .o_tick       (o_tick),
        .o_wrap       (o_wrap),
        .o_done       (o_done)
    );

    task automatic sb_push(input string t, input logic [15:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the pulses for exactly one rising edge; returns on the falling
    // edge right after that rising edge.
    task automatic pulse(input logic rs, input logic lp, input logic cl);
        @(negedge clk);
        i_run_stop = rs;
        i_lap      = lp;
        i_clear    = cl;
        @(negedge clk);
        i_run_stop = 1'b0;
        i_lap      = 1'b0;
        i_clear    = 1'b0;
    endtask

    task automatic check_all_zero(input string t);
        sb_push({t, "_bcd"}, 16'h0000);  check(o_bcd);
        sb_push({t, "_run"}, 16'd0);     check(16'(o_running));
        sb_push({t, "_lap"}, 16'd0);     check(16'(o_lap_active));
        sb_push({t, "_tick"}, 16'd0);    check(16'(o_tick));
        sb_push({t, "_wrap"}, 16'd0);    check(16'(o_wrap));
        sb_push({t, "_done"}, 16'd0);    check(16'(o_done));
    endtask

    initial begin
        reset      = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
        i_down     = 1'b0;
        i_preset   = 16'h0000;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        cycles(2);
        check_all_zero("post_reset");

        // Preset clamping: F and A digits saturate to 9.
        i_down = 1'b1; i_preset = 16'hFA03;
        pulse(0, 0, 1);
        sb_push("clamp_bcd", 16'h9903); check(o_bcd);
        i_down = 1'b0;
        pulse(0, 0, 1);
        sb_push("clear_up_bcd", 16'h0000); check(o_bcd);

        // Up count: first tick DIV cycles after entering RUN, count one later.
        pulse(1, 0, 0);
        cycles(9);
        sb_push("tick_early", 16'd0); check(16'(o_tick));
        cycles(1);
        sb_push("tick_first", 16'd1); check(16'(o_tick));
        sb_push("bcd_at_tick", 16'h0000); check(o_bcd);
        cycles(1);
        sb_push("bcd_after_tick", 16'h0001); check(o_bcd);
        sb_push("tick_single", 16'd0); check(16'(o_tick));
        cycles(89);
        sb_push("bcd_0009", 16'h0009); check(o_bcd);
        cycles(1);
        sb_push("bcd_0010", 16'h0010); check(o_bcd);
        sb_push("run_up", 16'd1); check(16'(o_running));
        pulse(1, 0, 0);
        sb_push("stopped", 16'd0); check(16'(o_running));
        cycles(500);
        sb_push("hold_bcd", 16'h0010); check(o_bcd);
        sb_push("hold_tick", 16'd0); check(16'(o_tick));

        // Rollover 9998 -> 9999 -> 0000 with a one-cycle wrap pulse.
        i_down = 1'b1; i_preset = 16'h9998;
        pulse(0, 0, 1);
        sb_push("preload_9998", 16'h9998); check(o_bcd);
        i_down = 1'b0;
        pulse(1, 0, 0);
        cycles(20);
        sb_push("bcd_9999", 16'h9999); check(o_bcd);
        sb_push("wrap_before", 16'd0); check(16'(o_wrap));
        cycles(1);
        sb_push("bcd_rolled", 16'h0000); check(o_bcd);
        sb_push("wrap_pulse", 16'd1); check(16'(o_wrap));
        sb_push("run_after_wrap", 16'd1); check(16'(o_running));
        cycles(1);
        sb_push("wrap_single", 16'd0); check(16'(o_wrap));
        cycles(9);
        sb_push("bcd_0001", 16'h0001); check(o_bcd);
        pulse(1, 0, 0);

        // Lap hold while the live count keeps going.
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        cycles(251);
        sb_push("bcd_0025", 16'h0025); check(o_bcd);
        pulse(0, 1, 0);
        sb_push("lap_frozen", 16'h0025); check(o_bcd);
        sb_push("lap_active", 16'd1); check(16'(o_lap_active));
        sb_push("lap_running", 16'd1); check(16'(o_running));
        cycles(149);
        sb_push("lap_still_frozen", 16'h0025); check(o_bcd);
        pulse(0, 1, 0);
        sb_push("lap_release_bcd", 16'h0040); check(o_bcd);
        sb_push("lap_release_flag", 16'd0); check(16'(o_lap_active));
        pulse(1, 0, 0);

        // Countdown from 3 stops itself at zero.
        i_down = 1'b1; i_preset = 16'h0003;
        pulse(0, 0, 1);
        sb_push("preset_0003", 16'h0003); check(o_bcd);
        pulse(1, 0, 0);
        cycles(30);
        sb_push("down_0001", 16'h0001); check(o_bcd);
        sb_push("done_early", 16'd0); check(16'(o_done));
        cycles(1);
        sb_push("down_zero", 16'h0000); check(o_bcd);
        sb_push("done_pulse", 16'd1); check(16'(o_done));
        sb_push("down_stopped", 16'd0); check(16'(o_running));
        cycles(1);
        sb_push("done_single", 16'd0); check(16'(o_done));
        cycles(50);
        sb_push("down_hold_zero", 16'h0000); check(o_bcd);
        sb_push("down_no_tick", 16'd0); check(16'(o_tick));

        // Countdown started at zero: done on the first tick, count stays 0.
        i_preset = 16'h0000;
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        cycles(10);
        sb_push("zero_start_run", 16'd1); check(16'(o_running));
        cycles(1);
        sb_push("zero_start_done", 16'd1); check(16'(o_done));
        sb_push("zero_start_stop", 16'd0); check(16'(o_running));
        sb_push("zero_start_bcd", 16'h0000); check(o_bcd);

        // run_stop beats clear in STOP; clear in RUN is ignored.
        i_preset = 16'h0042;
        pulse(0, 0, 1);
        i_down = 1'b0;
        pulse(1, 0, 1);
        sb_push("simul_bcd", 16'h0042); check(o_bcd);
        sb_push("simul_run", 16'd1); check(16'(o_running));
        pulse(0, 0, 1);
        sb_push("clear_in_run_bcd", 16'h0042); check(o_bcd);
        sb_push("clear_in_run_run", 16'd1); check(16'(o_running));
        cycles(9);
        sb_push("up_after_latch", 16'h0043); check(o_bcd);

        // Asynchronous reset in LAP_RUN.
        pulse(0, 1, 0);
        sb_push("pre_reset_lap", 16'd1); check(16'(o_lap_active));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        pulse(1, 0, 0);
        sb_push("restart_bcd", 16'h0000); check(o_bcd);
        sb_push("restart_run", 16'd1); check(16'(o_running));
        cycles(10);
        sb_push("restart_tick", 16'd1); check(16'(o_tick));
        cycles(1);
        sb_push("restart_0001", 16'h0001); check(o_bcd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
